universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the single-mode left-shift register.
- Per-cycle selectable mode: hold, parallel load, logical shift left/right, rotate left/right, arithmetic shift right.
- Serial in/out on both ends, so instances can be cascaded.
- Saturating shift counter and `drained` flag let a parallel word be serialised and its completion detected.
- Used as the datapath core for serialisers, LFSR experiments and bit-manipulation examples in the simulation set.

Parameters:
- N, 8, register width in bits; legal range 2 to 64.
- CW, $clog2(N+1), shift_count width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, the register and counter hold regardless of mode.
- mode  in  3  operation select, shift_mode_t from shift_pkg.
- data_in  in  N  parallel load value.
- serial_in_msb  in  1  bit entering bit N-1 on SHR.
- serial_in_lsb  in  1  bit entering bit 0 on SHL.
- data_out  out  N  register contents.
- serial_out_msb  out  1  equals data_out[N-1]; the bit leaving on SHL/ROL.
- serial_out_lsb  out  1  equals data_out[0]; the bit leaving on SHR/ROR/ASR.
- shift_count  out  CW  shift ops since the last LOAD, saturating at N.
- drained  out  1  high when shift_count == N.

Behaviour:
- All state updates on the rising clock edge. Priority: reset > !enable > mode.
- Reset (synchronous, active-high): data = 0, shift_count = 0, so drained = 0. reset asserted mid-stream clears state on that edge; the mode input is ignored that cycle.
- enable = 0: data and shift_count hold.
- mode encodings, with enable = 1:
  - HOLD=0: data holds; count holds.
  - LOAD=1: data <= data_in; count <= 0.
  - SHL=2: data <= {data[N-2:0], serial_in_lsb}.
  - SHR=3: data <= {serial_in_msb, data[N-1:1]}.
  - ROL=4: data <= {data[N-2:0], data[N-1]}.
  - ROR=5: data <= {data[0], data[N-1:1]}.
  - ASR=6: data <= {data[N-1], data[N-1:1]}.
  - 7: reserved; behaves as HOLD, count unchanged.
- Counter: each SHL/SHR/ROL/ROR/ASR cycle increments shift_count while < N. At N it saturates and further shifts leave it at N.
- drained = (shift_count == N). It is combinational from the count register, so it asserts in the same cycle the Nth shift result appears on data_out.
- Latency: data_out, shift_count and drained reflect a command one cycle after the edge that samples it (registered outputs).
- serial_out_msb and serial_out_lsb are combinational taps of the data register, so they present the bit that the next shift will remove.
- Rotate preserves popcount. After N consecutive ROL or ROR operations, data returns to its original value and drained = 1.
- N=2 boundary: every mode must remain well-formed; no zero-width slices.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined: adds output port parity_out (1 bit) = XOR-reduction of the data register. It is registered, computed from the next-state value, so it is coincident with data_out. Reset value is 0.
- Undefined: parity_out port and logic are absent; all other behaviour is identical.

Decomposition:
- shift_pkg holds:
  - typedef enum logic [2:0] shift_mode_t {HOLD, LOAD, SHL, SHR, ROL, ROR, ASR}.
  - localparam MODE_W = 3.
- One sub-module is natural: sat_counter #(MAX=N). It provides clear, increment and saturate, with output count and at_max. It is instantiated for shift_count/drained.
- The next-state mux stays in universal_shift_register.

Test Plan:
- Reset: N=8, assert reset 2 cycles with mode=LOAD, data_in=8'hFF -> data_out=8'h00, shift_count=0, drained=0.
- Serialise: LOAD 8'hA5, then 8× SHL with serial_in_lsb=0 -> serial_out_msb sequence is 1,0,1,0,0,1,0,1; data_out=8'h00; drained rises on the 8th shift and stays with shift_count=8 after a 9th shift.
- Rotate: LOAD 8'h81, then 4× ROR -> 8'h18; 4 more -> 8'h81 with drained=1. LOAD 8'h01, ROL -> 8'h02.
- ASR/SHR: LOAD 8'h90; ASR -> 8'hC8; SHR with serial_in_msb=1 -> 8'hE4; mode=7 for 1 cycle -> 8'hE4 held, count=2.
- Enable/reset priority: LOAD 8'h3C, enable=0 with SHL for 3 cycles -> 8'h3C, count 0. Then reset=1 together with enable=1 and LOAD 8'hFF -> 8'h00.
- USR_PARITY_EN: LOAD 8'h07 -> parity_out=1; SHL with serial_in_lsb=0 -> 8'h0E, parity_out=1; SHL with serial_in_lsb=1 -> 8'h1D, parity_out=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared mode encoding for universal_shift_register and its users.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        HOLD = 3'd0,
        LOAD = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6
    } shift_mode_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags count == MAX.
module sat_counter #(
    parameter int unsigned MAX = 8,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         increment,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with per-cycle mode, serial taps and drain counter.
// Optional parity_out port is enabled by defining USR_PARITY_EN.
module universal_shift_register
    import shift_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  shift_mode_t   mode,
    input  logic [N-1:0]  data_in,
    input  logic          serial_in_msb,
    input  logic          serial_in_lsb,
    output logic [N-1:0]  data_out,
    output logic          serial_out_msb,
    output logic          serial_out_lsb,
    output logic [CW-1:0] shift_count,
    output logic          drained
`ifdef USR_PARITY_EN
    ,
    output logic          parity_out
`endif
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_next;
    logic         is_shift;
    logic         is_load;

    // data_next already folds in the enable hold so parity can track it exactly.
    always_comb begin
        data_next = data_q;
        is_shift  = 1'b0;
        is_load   = 1'b0;
        if (enable) begin
            case (mode)
                LOAD: begin
                    data_next = data_in;
                    is_load   = 1'b1;
                end
                SHL: begin
                    data_next = {data_q[N-2:0], serial_in_lsb};
                    is_shift  = 1'b1;
                end
                SHR: begin
                    data_next = {serial_in_msb, data_q[N-1:1]};
                    is_shift  = 1'b1;
                end
                ROL: begin
                    data_next = {data_q[N-2:0], data_q[N-1]};
                    is_shift  = 1'b1;
                end
                ROR: begin
                    data_next = {data_q[0], data_q[N-1:1]};
                    is_shift  = 1'b1;
                end
                ASR: begin
                    data_next = {data_q[N-1], data_q[N-1:1]};
                    is_shift  = 1'b1;
                end
                default: begin
                    data_next = data_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_next;
        end
    end

    sat_counter #(
        .MAX (N),
        .W   (CW)
    ) u_shift_count (
        .clock     (clock),
        .reset     (reset),
        .clear     (is_load),
        .increment (is_shift),
        .count     (shift_count),
        .at_max    (drained)
    );

    assign data_out       = data_q;
    assign serial_out_msb = data_q[N-1];
    assign serial_out_lsb = data_q[0];

`ifdef USR_PARITY_EN
    logic parity_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_next;
        end
    end

    assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed, table-driven bench for universal_shift_register (N=8 plus an N=2 instance).
module tb_universal_shift_register;
    import shift_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    shift_mode_t mode;
    logic [7:0]  data_in;
    logic        serial_in_msb;
    logic        serial_in_lsb;
    logic [7:0]  data_out;
    logic        serial_out_msb;
    logic        serial_out_lsb;
    logic [3:0]  shift_count;
    logic        drained;

    logic        n2_reset;
    logic        n2_enable;
    shift_mode_t n2_mode;
    logic [1:0]  n2_data_in;
    logic        n2_serial_in_msb;
    logic        n2_serial_in_lsb;
    logic [1:0]  n2_data_out;
    logic        n2_serial_out_msb;
    logic        n2_serial_out_lsb;
    logic [1:0]  n2_shift_count;
    logic        n2_drained;

`ifdef USR_PARITY_EN
    logic parity_out;
    logic n2_parity_out;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clock = ~clock;

    universal_shift_register #(.N(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .data_in        (data_in),
        .serial_in_msb  (serial_in_msb),
        .serial_in_lsb  (serial_in_lsb),
        .data_out       (data_out),
        .serial_out_msb (serial_out_msb),
        .serial_out_lsb (serial_out_lsb),
        .shift_count    (shift_count),
        .drained        (drained)
`ifdef USR_PARITY_EN
        ,
        .parity_out     (parity_out)
`endif
    );

    universal_shift_register #(.N(2)) dut_n2 (
        .clock          (clock),
        .reset          (n2_reset),
        .enable         (n2_enable),
        .mode           (n2_mode),
        .data_in        (n2_data_in),
        .serial_in_msb  (n2_serial_in_msb),
        .serial_in_lsb  (n2_serial_in_lsb),
        .data_out       (n2_data_out),
        .serial_out_msb (n2_serial_out_msb),
        .serial_out_lsb (n2_serial_out_lsb),
        .shift_count    (n2_shift_count),
        .drained        (n2_drained)
`ifdef USR_PARITY_EN
        ,
        .parity_out     (n2_parity_out)
`endif
    );

    typedef struct {
        logic        rst;
        logic        en;
        shift_mode_t md;
        logic [7:0]  din;
        logic        sin_msb;
        logic        sin_lsb;
        logic [7:0]  exp_data;
        logic [3:0]  exp_cnt;
        logic        exp_drn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic en, input shift_mode_t md,
                                input logic [7:0] din, input logic sin_msb, input logic sin_lsb,
                                input logic [7:0] exp_data, input logic [3:0] exp_cnt,
                                input logic exp_drn);
        vec_t v;
        v.rst = rst; v.en = en; v.md = md; v.din = din;
        v.sin_msb = sin_msb; v.sin_lsb = sin_lsb;
        v.exp_data = exp_data; v.exp_cnt = exp_cnt; v.exp_drn = exp_drn;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic en, input shift_mode_t md,
                         input logic [7:0] din, input logic sin_msb, input logic sin_lsb);
        @(negedge clock);
        reset = rst; enable = en; mode = md; data_in = din;
        serial_in_msb = sin_msb; serial_in_lsb = sin_lsb;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_n2(input logic rst, input shift_mode_t md, input logic [1:0] din,
                            input logic sin_msb, input logic sin_lsb);
        @(negedge clock);
        n2_reset = rst; n2_enable = 1'b1; n2_mode = md; n2_data_in = din;
        n2_serial_in_msb = sin_msb; n2_serial_in_lsb = sin_lsb;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] pattern;
        reset = 1'b1; enable = 1'b1; mode = LOAD; data_in = 8'hFF;
        serial_in_msb = 1'b0; serial_in_lsb = 1'b0;
        n2_reset = 1'b1; n2_enable = 1'b1; n2_mode = HOLD; n2_data_in = 2'b00;
        n2_serial_in_msb = 1'b0; n2_serial_in_lsb = 1'b0;

        // reset, rotate, ASR/SHR/reserved, enable and reset priority
        vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'h00, 4'd0, 0));
        vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'h00, 4'd0, 0));
        vecs.push_back(mk(0, 1, LOAD, 8'h81, 0, 0, 8'h81, 4'd0, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'hC0, 4'd1, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h60, 4'd2, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h30, 4'd3, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h18, 4'd4, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 1, 1, 8'h0C, 4'd5, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h06, 4'd6, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h03, 4'd7, 0));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'h81, 4'd8, 1));
        vecs.push_back(mk(0, 1, ROR,  8'h00, 0, 0, 8'hC0, 4'd8, 1));
        vecs.push_back(mk(0, 1, LOAD, 8'h01, 0, 0, 8'h01, 4'd0, 0));
        vecs.push_back(mk(0, 1, ROL,  8'h00, 0, 0, 8'h02, 4'd1, 0));
        vecs.push_back(mk(0, 1, LOAD, 8'h90, 0, 0, 8'h90, 4'd0, 0));
        vecs.push_back(mk(0, 1, ASR,  8'h00, 0, 0, 8'hC8, 4'd1, 0));
        vecs.push_back(mk(0, 1, SHR,  8'h00, 1, 0, 8'hE4, 4'd2, 0));
        vecs.push_back(mk(0, 1, shift_mode_t'(3'd7), 8'hFF, 0, 0, 8'hE4, 4'd2, 0));
        vecs.push_back(mk(0, 1, HOLD, 8'hFF, 1, 1, 8'hE4, 4'd2, 0));
        vecs.push_back(mk(0, 1, LOAD, 8'h3C, 0, 0, 8'h3C, 4'd0, 0));
        vecs.push_back(mk(0, 0, SHL,  8'h00, 1, 1, 8'h3C, 4'd0, 0));
        vecs.push_back(mk(0, 0, SHL,  8'h00, 1, 1, 8'h3C, 4'd0, 0));
        vecs.push_back(mk(0, 0, SHL,  8'h00, 1, 1, 8'h3C, 4'd0, 0));
        vecs.push_back(mk(1, 1, LOAD, 8'hFF, 0, 0, 8'h00, 4'd0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].md, vecs[i].din,
                  vecs[i].sin_msb, vecs[i].sin_lsb);
            check($sformatf("vec%0d data_out", i), 64'(data_out), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d shift_count", i), 64'(shift_count), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d drained", i), 64'(drained), 64'(vecs[i].exp_drn));
            check($sformatf("vec%0d serial_out_msb", i), 64'(serial_out_msb), 64'(vecs[i].exp_data[7]));
            check($sformatf("vec%0d serial_out_lsb", i), 64'(serial_out_lsb), 64'(vecs[i].exp_data[0]));
        end

        // Serialise 0xA5 out of the MSB end, then one extra shift to confirm saturation
        apply(0, 1, LOAD, 8'hA5, 0, 0);
        pattern = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ser msb_before_shift%0d", i), 64'(serial_out_msb), 64'(pattern[7 - i]));
            check($sformatf("ser drained_before_shift%0d", i), 64'(drained), 64'd0);
            apply(0, 1, SHL, 8'h00, 0, 0);
        end
        check("ser data_after_8", 64'(data_out), 64'h00);
        check("ser count_after_8", 64'(shift_count), 64'd8);
        check("ser drained_after_8", 64'(drained), 64'd1);
        apply(0, 1, SHL, 8'h00, 0, 0);
        check("ser count_after_9", 64'(shift_count), 64'd8);
        check("ser drained_after_9", 64'(drained), 64'd1);

`ifdef USR_PARITY_EN
        apply(1, 1, LOAD, 8'hFF, 0, 0);
        check("par reset", 64'(parity_out), 64'd0);
        apply(0, 1, LOAD, 8'h07, 0, 0);
        check("par load07", 64'(parity_out), 64'd1);
        apply(0, 1, SHL, 8'h00, 0, 0);
        check("par data0E", 64'(data_out), 64'h0E);
        check("par shl0", 64'(parity_out), 64'd1);
        apply(0, 1, SHL, 8'h00, 0, 1);
        check("par data1D", 64'(data_out), 64'h1D);
        check("par shl1", 64'(parity_out), 64'd0);
`endif

        // N=2 boundary: every mode on a two-bit register
        apply_n2(1, HOLD, 2'b00, 0, 0);
        check("n2 reset data", 64'(n2_data_out), 64'd0);
        apply_n2(0, LOAD, 2'b10, 0, 0);
        check("n2 load", 64'(n2_data_out), 64'b10);
        apply_n2(0, ROL, 2'b00, 0, 0);
        check("n2 rol", 64'(n2_data_out), 64'b01);
        check("n2 rol count", 64'(n2_shift_count), 64'd1);
        apply_n2(0, ROR, 2'b00, 0, 0);
        check("n2 ror", 64'(n2_data_out), 64'b10);
        check("n2 ror drained", 64'(n2_drained), 64'd1);
        apply_n2(0, ASR, 2'b00, 0, 0);
        check("n2 asr", 64'(n2_data_out), 64'b11);
        check("n2 asr count", 64'(n2_shift_count), 64'd2);
        apply_n2(0, SHL, 2'b00, 0, 0);
        check("n2 shl", 64'(n2_data_out), 64'b10);
        apply_n2(0, SHR, 2'b00, 0, 0);
        check("n2 shr", 64'(n2_data_out), 64'b01);
        check("n2 serial_out_lsb", 64'(n2_serial_out_lsb), 64'd1);
        check("n2 serial_out_msb", 64'(n2_serial_out_msb), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
